// File: rtl/truth_table_sweep.sv
// truth_table_sweep: exhaustive stimulus engine; drives every N_IN-bit vector for HOLD cycles and checks DUT outputs against EXPECT.
// Latency: stim=0/busy=1 one cycle after the start edge; done rises 2^N_IN*HOLD cycles after that edge.
// Flow control: none; start is ignored while a sweep is running. Optional macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sweep #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int HOLD  = 20,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] dut_in,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    mismatch_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic             fail_seen
);

  // Hold counter only needs to reach HOLD-1; keep it at least one bit wide.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] LAST_IDX  = '1;

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [HW-1:0]    hold_q;
  logic [N_IN-1:0]  stim_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [N_IN:0]    cnt_q;
  logic [N_IN-1:0]  first_q;
  logic             seen_q;

  // Expected table viewed as one entry per vector so stim indexes it directly.
  logic [N_OUT-1:0] exp_tbl [2**N_IN];
  logic             miss;

  for (genvar g = 0; g < 2**N_IN; g++) begin : g_tbl
    assign exp_tbl[g] = EXPECT[g*N_OUT +: N_OUT];
  end

  assign miss = (dut_in != exp_tbl[stim_q]);

  // Sweep sequencer: launch, per-vector hold, sample/compare at window end, terminal detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_DRIVE;
            stim_q  <= '0;
            hold_q  <= HOLD_LAST;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else begin
            if (miss) begin
              cnt_q <= cnt_q + 1'b1;
              if (!seen_q) begin
                first_q <= stim_q;
                seen_q  <= 1'b1;
              end
            end
            // Terminal index is detected explicitly so stim never wraps.
            if ((STOP_ON_FAIL && miss) || (stim_q == LAST_IDX)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= !miss && (cnt_q == '0);
            end else begin
              stim_q <= stim_q + 1'b1;
              hold_q <= HOLD_LAST;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail   = first_q;
  assign fail_seen    = seen_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep: drives two sweep engines (4-in/1-out/HOLD=20 and 2-in/3-out/HOLD=1) with faulty DUT models.
// A cycle-indexed reference computes the expected outputs from launch time and fault set alone.
// Directed scenarios come first, then randomized fault sets, start timing and resets.
module tb_truth_table_sweep;

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam logic [15:0] EXPA = 16'hB6D3;
  localparam logic [11:0] EXPB = 12'o5273;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, startA, rstB, startB;
  logic       dinA;
  logic [2:0] dinB;
  logic [3:0] stimA, ffA;
  logic [4:0] cntA;
  logic       busyA, doneA, passA, fsA;
  logic [1:0] stimB, ffB;
  logic [2:0] cntB;
  logic       busyB, doneB, passB, fsB;

  bit [15:0]  fltA = '0, fltB = '0;
  logic [2:0] mskB = 3'b001;
  logic [15:0] expa_v = EXPA;
  logic [11:0] expb_v = EXPB;

  // DUT models: the ideal table with the selected indices corrupted.
  assign dinA = expa_v[stimA] ^ fltA[stimA];
  assign dinB = expb_v[int'(stimB)*3 +: 3] ^ (fltB[stimB] ? mskB : 3'b000);

  truth_table_sweep #(.N_IN(4), .N_OUT(1), .HOLD(20), .EXPECT(EXPA)) u_a (
    .clk(clk), .rst(rstA), .start(startA), .dut_in(dinA), .stim(stimA), .busy(busyA),
    .done(doneA), .pass(passA), .mismatch_cnt(cntA), .first_fail(ffA), .fail_seen(fsA));

  truth_table_sweep #(.N_IN(2), .N_OUT(3), .HOLD(1), .EXPECT(EXPB)) u_b (
    .clk(clk), .rst(rstB), .start(startB), .dut_in(dinB), .stim(stimB), .busy(busyB),
    .done(doneB), .pass(passB), .mismatch_cnt(cntB), .first_fail(ffB), .fail_seen(fsB));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Expected outputs k edges after the launch edge, given the fault set of that sweep.
  function automatic void mdl(input bit act, input int k, input int nvec, input int hold,
                              input bit [15:0] f, output int o_stim, output int o_busy,
                              output int o_done, output int o_pass, output int o_cnt,
                              output int o_ff, output int o_fs);
    int s, first, sc;
    o_stim = 0; o_busy = 0; o_done = 0; o_pass = 0; o_cnt = 0; o_ff = 0; o_fs = 0;
    if (!act) return;
    s = k / hold;
    first = -1;
    for (int i = nvec - 1; i >= 0; i--) if (f[i]) first = i;
    if (STOP && first >= 0 && s > first) begin
      o_stim = first; o_done = 1; o_cnt = 1; o_ff = first; o_fs = 1;
      return;
    end
    sc = (s < nvec) ? s : nvec;
    for (int i = 0; i < sc; i++) if (f[i]) o_cnt++;
    o_fs = (o_cnt > 0) ? 1 : 0;
    o_ff = (first >= 0 && first < sc) ? first : 0;
    if (s < nvec) begin
      o_stim = s; o_busy = 1;
    end else begin
      o_stim = nvec - 1; o_done = 1; o_pass = (o_cnt == 0) ? 1 : 0;
    end
  endfunction

  // Reference state: whether a sweep was launched since reset, and edges since that launch.
  bit actA = 0, actB = 0;
  int kA = 0, kB = 0;
  bit [15:0] snapA = '0, snapB = '0;

  always @(posedge clk) begin : ref_upd
    int s, b, d, p, c, f, g;
    mdl(actA, kA, 16, 20, snapA, s, b, d, p, c, f, g);
    if (rstA) begin actA = 0; kA = 0; end
    else if (startA && b == 0) begin actA = 1; kA = 0; snapA = fltA; end
    else if (actA) kA++;
    mdl(actB, kB, 4, 1, snapB, s, b, d, p, c, f, g);
    if (rstB) begin actB = 0; kB = 0; end
    else if (startB && b == 0) begin actB = 1; kB = 0; snapB = fltB; end
    else if (actB) kB++;
  end

  always @(negedge clk) begin : cmp
    int es, eb, ed, ep, ec, ef, eg;
    if (chk_en) begin
      mdl(actA, kA, 16, 20, snapA, es, eb, ed, ep, ec, ef, eg);
      chk("A_stim", 32'(stimA), 32'(es)); chk("A_busy", 32'(busyA), 32'(eb));
      chk("A_done", 32'(doneA), 32'(ed)); chk("A_pass", 32'(passA), 32'(ep));
      chk("A_cnt", 32'(cntA), 32'(ec));   chk("A_first", 32'(ffA), 32'(ef));
      chk("A_seen", 32'(fsA), 32'(eg));
      mdl(actB, kB, 4, 1, snapB, es, eb, ed, ep, ec, ef, eg);
      chk("B_stim", 32'(stimB), 32'(es)); chk("B_busy", 32'(busyB), 32'(eb));
      chk("B_done", 32'(doneB), 32'(ed)); chk("B_pass", 32'(passB), 32'(ep));
      chk("B_cnt", 32'(cntB), 32'(ec));   chk("B_first", 32'(ffB), 32'(ef));
      chk("B_seen", 32'(fsB), 32'(eg));
    end
  end

  task automatic pulse_a();
    startA = 1'b1; @(negedge clk); startA = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (doneA !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk("A_sweep_timeout", 32'(doneA), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstA = 1'b1; rstB = 1'b1; startA = 1'b0; startB = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("A_reset_stim", 32'(stimA), 32'd0); chk("A_reset_done", 32'(doneA), 32'd0);
    chk("B_reset_cnt", 32'(cntB), 32'd0);
    rstA = 1'b0; rstB = 1'b0;

    // Clean sweep: done exactly 320 edges after launch.
    @(negedge clk); pulse_a();
    chk("A_launch_stim", 32'(stimA), 32'd0); chk("A_launch_busy", 32'(busyA), 32'd1);
    repeat (100) @(negedge clk);
    chk("A_clean_stim_k100", 32'(stimA), 32'd5);
    repeat (219) @(negedge clk);
    chk("A_clean_done_k319", 32'(doneA), 32'd0);
    @(negedge clk);
    chk("A_clean_done_k320", 32'(doneA), 32'd1); chk("A_clean_pass", 32'(passA), 32'd1);
    chk("A_clean_cnt", 32'(cntA), 32'd0); chk("A_clean_stim", 32'(stimA), 32'd15);

    // Single fault at index 5.
    fltA = 16'h0020; pulse_a();
    repeat (320) @(negedge clk);
    chk("A_f5_done", 32'(doneA), 32'd1); chk("A_f5_cnt", 32'(cntA), 32'd1);
    chk("A_f5_first", 32'(ffA), 32'd5); chk("A_f5_seen", 32'(fsA), 32'd1);
    chk("A_f5_pass", 32'(passA), 32'd0);

    // Faults at indices 3 and 9.
    fltA = 16'h0208; pulse_a();
`ifdef SWEEP_STOP_ON_FAIL_EN
    repeat (79) @(negedge clk);
    chk("A_f39_done_k79", 32'(doneA), 32'd0);
    @(negedge clk);
    chk("A_f39_done_k80", 32'(doneA), 32'd1); chk("A_f39_stim", 32'(stimA), 32'd3);
    chk("A_f39_cnt", 32'(cntA), 32'd1);
`else
    repeat (320) @(negedge clk);
    chk("A_f39_cnt", 32'(cntA), 32'd2); chk("A_f39_first", 32'(ffA), 32'd3);
    chk("A_f39_done", 32'(doneA), 32'd1);
`endif

    // Reset mid-sweep at stim=7, then a clean restart.
    fltA = '0; pulse_a();
    repeat (145) @(negedge clk);
    chk("A_mid_stim", 32'(stimA), 32'd7);
    rstA = 1'b1; @(negedge clk); rstA = 1'b0;
    chk("A_rst_stim", 32'(stimA), 32'd0); chk("A_rst_busy", 32'(busyA), 32'd0);
    pulse_a();
    chk("A_restart_stim", 32'(stimA), 32'd0); chk("A_restart_cnt", 32'(cntA), 32'd0);
    wait_done_a(400);

    // Start held high for a whole sweep, then relaunch from DONE.
    startA = 1'b1; @(negedge clk);
    repeat (319) @(negedge clk);
    chk("A_held_done_k319", 32'(doneA), 32'd0);
    @(negedge clk);
    chk("A_held_done_k320", 32'(doneA), 32'd1);
    @(negedge clk);
    chk("A_held_relaunch_busy", 32'(busyA), 32'd1); chk("A_held_relaunch_stim", 32'(stimA), 32'd0);
    startA = 1'b0;
    wait_done_a(400);

    // Random fault sets and launch gaps.
    for (int r = 0; r < 4; r++) begin
      fltA = 16'($urandom & $urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse_a();
      wait_done_a(400);
    end

    // Minimum hold on the small engine: one vector per edge.
    startB = 1'b1; @(negedge clk); startB = 1'b0;
    chk("B_k0_stim", 32'(stimB), 32'd0); @(negedge clk);
    chk("B_k1_stim", 32'(stimB), 32'd1); @(negedge clk);
    chk("B_k2_stim", 32'(stimB), 32'd2); @(negedge clk);
    chk("B_k3_stim", 32'(stimB), 32'd3); chk("B_k3_done", 32'(doneB), 32'd0); @(negedge clk);
    chk("B_k4_done", 32'(doneB), 32'd1); chk("B_k4_pass", 32'(passB), 32'd1);

    // Random start/reset traffic; faults only change while no sweep runs.
    for (int c = 0; c < 400; c++) begin
      int s, b, d, p, n, f, g;
      @(negedge clk);
      mdl(actB, kB, 4, 1, snapB, s, b, d, p, n, f, g);
      if (b == 0) begin
        fltB = 16'($urandom_range(0, 15));
        mskB = 3'($urandom_range(1, 7));
      end
      startB = ($urandom_range(0, 3) == 0);
      rstB   = ($urandom_range(0, 19) == 0);
    end
    startB = 1'b0; rstB = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
